servo_pwm_bank: RTL and testbench
=================================

# servo_pwm_bank

Parametrised multi-channel servo pulse generator for the robot top level. It replaces fixed two-servo wiring with NCH independent channels sharing one frame counter. Each channel accepts signed speed/position commands through a valid/ready port and applies per-frame slew limiting and width clamping. The frame-start strobe is exported so the sensor and UART logic can schedule work once per servo frame.

## Interface
- NCH, 2: number of servo channels (≥1)
- CMD_W, 8: signed command width
- PERIOD_TICKS, 2000000: frame length in clk cycles (20 ms @ 100 MHz)
- CENTER_TICKS, 150000: pulse width for command 0
- STEP_TICKS, 1000: pulse-width ticks per command unit
- MIN_TICKS, 100000 / MAX_TICKS, 200000: pulse-width clamp limits
- SLEW, 4: max command-unit change per frame; 0 = unlimited (immediate)
- clk  in  1  system clock; only clock
- reset  in  1  synchronous, active-high
- enable  in  1  output enable; low forces all servo pins low
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  accept indication
- cmd_ch  in  max(1,clog2(NCH))  target channel
- cmd_val  in  CMD_W  signed target value
- cmd_err  out  1  one-cycle pulse on a rejected command
- servo  out  NCH  pulse outputs, one per channel
- frame_start  out  1  high during the cycle where cnt==0

## Operation
- Frame counter cnt counts 0..PERIOD_TICKS-1, then wraps to 0. It runs regardless of enable.
- Per channel registers:
  - tgt[i]: signed CMD_W, written by commands.
  - cur[i]: signed CMD_W, the slewed value.
  - wid[i]: active pulse width in ticks.
- Command handshake:
  - cmd_ready is 1 in every cycle except while reset is asserted.
  - Transfer occurs when cmd_valid && cmd_ready.
  - If cmd_ch < NCH: tgt[cmd_ch] <= cmd_val.
  - If cmd_ch ≥ NCH: no state changes, and cmd_err pulses for 1 cycle on the next cycle.
- Frame update happens at the edge where cnt==PERIOD_TICKS-1, for every channel:
  - Slew: cur <= tgt if |tgt-cur| ≤ SLEW or SLEW==0; otherwise cur <= cur ± SLEW toward tgt.
  - Width: wid <= clamp(CENTER_TICKS + cur_new·STEP_TICKS, MIN_TICKS, MAX_TICKS).
  - The width arithmetic is signed and wide enough that overflow is impossible before the clamp.
- Slewing and width updates continue while enable is low.
- servo[i] is a register loaded every cycle with enable && (cnt_next < wid_next[i]). Result: servo[i] is high exactly while cnt ∈ [0, wid[i]-1] and enable was high at the preceding edge. Outputs are glitch-free.
- frame_start is a register loaded with (cnt_next==0).

## Timing
- Reset values:
  - cnt=0, tgt=0, cur=0, wid=CENTER_TICKS (clamped).
  - servo=0, frame_start=0, cmd_ready=0, cmd_err=0.
- First cycle after reset deasserts:
  - cnt=1, cmd_ready=1, servo=0.
  - The first full pulse is produced in the frame beginning at the next wrap.
- Command-to-effect latency:
  - A command accepted when cnt ≤ PERIOD_TICKS-2 affects the frame starting at the next cnt==0.
  - A command accepted in the cycle where cnt==PERIOD_TICKS-1 is stored, but that frame's update uses the old tgt. It takes effect one frame later.
- Back-to-back commands to the same channel in one frame: the last one wins.
- enable:
  - Falling edge: servo drops at the next edge, including mid-pulse.
  - Rising edge mid-frame: servo rises at the next edge only if cnt+1 < wid.
- Reset asserted mid-frame returns every register to its reset value at that edge. It aborts any pulse in progress and any pending slew.
- wid=MAX_TICKS ≤ PERIOD_TICKS is a parameter requirement. The pulse never spans a frame boundary.

## Test plan
Bench parameters: NCH=3, PERIOD_TICKS=100, CENTER_TICKS=50, STEP_TICKS=2, MIN_TICKS=20, MAX_TICKS=80, SLEW=4, CMD_W=8.
- Reset, then run 3 frames with enable=1 -> all servo pins high 50 cycles per 100-cycle frame; frame_start high one cycle per frame, aligned with the rising edges; cmd_ready=0 during reset, then 1.
- cmd ch1=+10 at cnt=30 -> ch1 widths 58, 66, 70, 70 on the following frames; ch0 and ch2 stay at 50.
- cmd ch0=+100, then ch2=-100 -> ch0 width ramps by 8 per frame and saturates at 80; ch2 ramps down and saturates at 20.
- cmd_ch=3 with val=+5 -> cmd_err is a single-cycle pulse; no width changes. A cmd at cnt=99 is delayed exactly one extra frame.
- enable dropped at cnt=25 on a 50-wide pulse -> servo low from the next cycle; cnt and slewing continue. Re-enabling at cnt=10 of a later frame -> servo rises immediately with the current width.
- reset asserted at cnt=40 with ch1 slewing -> all outputs 0 at the next edge; after release, widths are back to 50 with no residual slew.

Source files
------------

// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank
// Multi-channel servo pulse generator. All channels share one frame counter.
// Every channel holds a signed target command. Once per frame the applied
// command moves toward the target by at most SLEW units. The applied command
// is then turned into a clamped pulse width, and that width drives the next
// frame's pulse.
//
// Ports
//   clk          system clock (only clock)
//   reset        synchronous, active-high reset
//   enable       output enable; low forces every servo pin low
//   cmd_valid    command strobe
//   cmd_ready    accept indication (low only while in reset)
//   cmd_ch       target channel of the command
//   cmd_val      signed target value
//   cmd_err      one-cycle pulse after a command for a nonexistent channel
//   servo        pulse outputs, one per channel
//   frame_start  high during the cycle where the frame counter is 0
module servo_pwm_bank #(
    parameter int NCH          = 2,
    parameter int CMD_W        = 8,
    parameter int PERIOD_TICKS = 2000000,
    parameter int CENTER_TICKS = 150000,
    parameter int STEP_TICKS   = 1000,
    parameter int MIN_TICKS    = 100000,
    parameter int MAX_TICKS    = 200000,
    parameter int SLEW         = 4,
    localparam int CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CH_W-1:0]         cmd_ch,
    input  logic signed [CMD_W-1:0] cmd_val,
    output logic                    cmd_err,
    output logic [NCH-1:0]          servo,
    output logic                    frame_start
);

    // Counter and width share one width: MAX_TICKS <= PERIOD_TICKS, so both fit.
    localparam int TW = $clog2(PERIOD_TICKS + 1);
    localparam logic [TW-1:0] LAST_CNT = TW'(PERIOD_TICKS - 1);
    localparam int WID_RST_I = (CENTER_TICKS < MIN_TICKS) ? MIN_TICKS :
                               ((CENTER_TICKS > MAX_TICKS) ? MAX_TICKS : CENTER_TICKS);
    localparam logic [TW-1:0] WID_RST = TW'(WID_RST_I);

    // Move the applied command at most SLEW units toward the target (SLEW==0: jump).
    function automatic logic signed [CMD_W-1:0] slew_step(
        input logic signed [CMD_W-1:0] cur_v,
        input logic signed [CMD_W-1:0] tgt_v
    );
        int diff_v;
        logic signed [CMD_W-1:0] res_v;
        diff_v = int'(tgt_v) - int'(cur_v);
        if ((SLEW == 32'sd0) || ((diff_v <= SLEW) && (diff_v >= -SLEW))) begin
            res_v = tgt_v;
        end else if (diff_v > 32'sd0) begin
            res_v = cur_v + CMD_W'(SLEW);
        end else begin
            res_v = cur_v - CMD_W'(SLEW);
        end
        return res_v;
    endfunction

    // Command to pulse width. The 64-bit signed arithmetic cannot overflow before the clamp.
    function automatic logic [TW-1:0] width_of(input logic signed [CMD_W-1:0] c_v);
        logic signed [63:0] raw_v;
        logic [TW-1:0]      res_v;
        raw_v = 64'(CENTER_TICKS) + (64'(c_v) * 64'(STEP_TICKS));
        if (raw_v < 64'(MIN_TICKS)) begin
            res_v = TW'(MIN_TICKS);
        end else if (raw_v > 64'(MAX_TICKS)) begin
            res_v = TW'(MAX_TICKS);
        end else begin
            res_v = TW'(raw_v);
        end
        return res_v;
    endfunction

    logic [TW-1:0]           cnt_r;
    logic                    armed_r;
    logic                    cmd_ready_r;
    logic                    cmd_err_r;
    logic                    frame_start_r;
    logic [NCH-1:0]          servo_r;
    logic signed [CMD_W-1:0] tgt_r [NCH];
    logic signed [CMD_W-1:0] cur_r [NCH];
    logic [TW-1:0]           wid_r [NCH];

    logic                    wrap_s;
    logic [TW-1:0]           cnt_next_s;
    logic                    armed_next_s;
    logic                    accept_s;
    logic                    ch_ok_s;
    logic signed [CMD_W-1:0] cur_next_s [NCH];
    logic [TW-1:0]           wid_next_s [NCH];
    logic [NCH-1:0]          servo_next_s;

    // Next counter, frame update values and next pin levels.
    always_comb begin
        wrap_s = (cnt_r == LAST_CNT);
        if (wrap_s) begin
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + TW'(1);
        end
        // Pins stay low until the first full frame after reset, so no partial pulse is emitted.
        armed_next_s = armed_r | wrap_s;
        accept_s     = cmd_valid & cmd_ready_r;
        ch_ok_s      = ({1'b0, cmd_ch} < (CH_W + 1)'(NCH));
        for (int i = 0; i < NCH; i++) begin
            cur_next_s[i] = slew_step(cur_r[i], tgt_r[i]);
            if (wrap_s) begin
                wid_next_s[i] = width_of(cur_next_s[i]);
            end else begin
                wid_next_s[i] = wid_r[i];
            end
            servo_next_s[i] = enable & armed_next_s & (cnt_next_s < wid_next_s[i]);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r         <= '0;
            armed_r       <= 1'b0;
            cmd_ready_r   <= 1'b0;
            cmd_err_r     <= 1'b0;
            frame_start_r <= 1'b0;
            servo_r       <= '0;
            for (int i = 0; i < NCH; i++) begin
                tgt_r[i] <= '0;
                cur_r[i] <= '0;
                wid_r[i] <= WID_RST;
            end
        end else begin
            cnt_r         <= cnt_next_s;
            armed_r       <= armed_next_s;
            cmd_ready_r   <= 1'b1;
            cmd_err_r     <= accept_s & ~ch_ok_s;
            frame_start_r <= (cnt_next_s == '0);
            servo_r       <= servo_next_s;
            for (int i = 0; i < NCH; i++) begin
                // The frame update reads the old target, so a command in the last cycle waits a frame.
                if (wrap_s) begin
                    cur_r[i] <= cur_next_s[i];
                end
                wid_r[i] <= wid_next_s[i];
                if (accept_s && ch_ok_s && (cmd_ch == CH_W'(i))) begin
                    tgt_r[i] <= cmd_val;
                end
            end
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign cmd_err     = cmd_err_r;
    assign servo       = servo_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank with a 100-tick frame and three channels.
// The bench tracks the expected frame counter itself. It measures every frame
// from cnt==0 and compares the per-channel high counts, the pulse shape,
// frame_start and cmd_err against hand-computed values.
module tb_servo_pwm_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_ch;
    logic [7:0] cmd_val;
    logic       cmd_err;
    logic [2:0] servo;
    logic       frame_start;

    int n_checks = 0;
    int n_errors = 0;
    int ecnt = 0;
    bit en_edge = 1'b0;
    int cmdk[2];
    int cmdc[2];
    int cmdv[2];
    int en_k = -1;
    int en_v = 0;

    servo_pwm_bank #(
        .NCH(3), .CMD_W(8), .PERIOD_TICKS(100), .CENTER_TICKS(50), .STEP_TICKS(2),
        .MIN_TICKS(20), .MAX_TICKS(80), .SLEW(4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_val(cmd_val),
        .cmd_err(cmd_err), .servo(servo), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: the expected counter follows the edge; sampling happens on the falling edge.
    task automatic step();
        @(posedge clk);
        en_edge = enable;
        if (reset) ecnt = 0;
        else ecnt = (ecnt == 99) ? 0 : ecnt + 1;
        @(negedge clk);
    endtask

    task automatic set_cmd(input int slot, input int k, input int c, input int v);
        cmdk[slot] = k;
        cmdc[slot] = c;
        cmdv[slot] = v;
    endtask

    // Run until cnt==0 and require the pins to stay low the whole time.
    task automatic idle_to_frame(input string tag);
        int hi;
        hi = 0;
        while (ecnt != 0) begin
            if (servo != 3'b000) hi++;
            step();
        end
        check_val(tag, hi, 0);
    endtask

    // Measure one frame starting at cnt==0, applying the queued commands and enable change.
    task automatic measure_frame(input string tag, input int w0, input int w1, input int w2,
                                 input int h0, input int h1, input int h2, input int errs);
        int w[3];
        int h[3];
        int hi[3];
        int bad;
        int fs;
        int fs0;
        int er;
        w = '{w0, w1, w2};
        h = '{h0, h1, h2};
        hi = '{0, 0, 0};
        bad = 0; fs = 0; fs0 = 0; er = 0;
        for (int k = 0; k < 100; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (servo[i]) hi[i]++;
                if (servo[i] !== (en_edge && (k < w[i]))) bad++;
            end
            if (frame_start) fs++;
            if ((k == 0) && frame_start) fs0 = 1;
            if (cmd_err) er++;
            cmd_valid = 1'b0;
            for (int s = 0; s < 2; s++) begin
                if (cmdk[s] == k) begin
                    cmd_valid = 1'b1;
                    cmd_ch    = 2'(cmdc[s]);
                    cmd_val   = 8'(cmdv[s]);
                end
            end
            if (en_k == k) enable = (en_v != 0);
            step();
        end
        cmd_valid = 1'b0;
        cmdk = '{-1, -1};
        en_k = -1;
        for (int i = 0; i < 3; i++) check_val($sformatf("%s_hi%0d", tag, i), hi[i], h[i]);
        check_val({tag, "_shape"}, bad, 0);
        check_val({tag, "_fs_count"}, fs, 1);
        check_val({tag, "_fs_at0"}, fs0, 1);
        check_val({tag, "_err"}, er, errs);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; cmd_valid = 1'b0; cmd_ch = 2'd0; cmd_val = 8'd0;
        cmdk = '{-1, -1};
        cmdc = '{0, 0};
        cmdv = '{0, 0};
        @(negedge clk);
        for (int i = 0; i < 3; i++) step();
        check_val("rst_ready", cmd_ready, 0);
        check_val("rst_servo", servo, 0);
        check_val("rst_fs", frame_start, 0);
        check_val("rst_err", cmd_err, 0);
        reset = 1'b0;
        step();
        check_val("post_rst_ready", cmd_ready, 1);
        check_val("post_rst_servo", servo, 0);
        check_val("post_rst_fs", frame_start, 0);
        idle_to_frame("first_partial_frame_idle");

        for (int f = 0; f < 3; f++) measure_frame($sformatf("A%0d", f), 50, 50, 50, 50, 50, 50, 0);

        // ch1 -> +10: slews 4 units per frame, 2 ticks per unit
        set_cmd(0, 30, 1, 10);
        measure_frame("B0", 50, 50, 50, 50, 50, 50, 0);
        measure_frame("B1", 50, 58, 50, 50, 58, 50, 0);
        measure_frame("B2", 50, 66, 50, 50, 66, 50, 0);
        measure_frame("B3", 50, 70, 50, 50, 70, 50, 0);
        measure_frame("B4", 50, 70, 50, 50, 70, 50, 0);

        // ch0 -> +100 saturates at 80, ch2 -> -100 saturates at 20
        set_cmd(0, 10, 0, 100);
        set_cmd(1, 20, 2, -100);
        measure_frame("C0", 50, 70, 50, 50, 70, 50, 0);
        measure_frame("C1", 58, 70, 42, 58, 70, 42, 0);
        measure_frame("C2", 66, 70, 34, 66, 70, 34, 0);
        measure_frame("C3", 74, 70, 26, 74, 70, 26, 0);
        measure_frame("C4", 80, 70, 20, 80, 70, 20, 0);
        measure_frame("C5", 80, 70, 20, 80, 70, 20, 0);

        // bad channel pulses cmd_err once; ch1 -> 0 at cnt 99 lands a frame late
        set_cmd(0, 40, 3, 5);
        set_cmd(1, 99, 1, 0);
        measure_frame("D0", 80, 70, 20, 80, 70, 20, 1);
        measure_frame("D1", 80, 70, 20, 80, 70, 20, 0);
        measure_frame("D2", 80, 62, 20, 80, 62, 20, 0);
        measure_frame("D3", 80, 54, 20, 80, 54, 20, 0);
        measure_frame("D4", 80, 50, 20, 80, 50, 20, 0);

        // enable drop at cnt 25, slewing continues, re-enable at cnt 10
        set_cmd(0, 5, 1, 8);
        en_k = 25; en_v = 0;
        measure_frame("E0", 80, 50, 20, 26, 26, 20, 0);
        measure_frame("E1", 80, 58, 20, 0, 0, 0, 0);
        en_k = 10; en_v = 1;
        measure_frame("E2", 80, 66, 20, 69, 55, 9, 0);
        measure_frame("E3", 80, 66, 20, 80, 66, 20, 0);

        // reset mid-frame while ch1 is slewing down
        set_cmd(0, 5, 1, -40);
        measure_frame("F0", 80, 66, 20, 80, 66, 20, 0);
        while (ecnt != 40) step();
        check_val("pre_reset_servo", servo, 3);
        reset = 1'b1;
        step();
        check_val("mid_rst_servo", servo, 0);
        check_val("mid_rst_fs", frame_start, 0);
        check_val("mid_rst_ready", cmd_ready, 0);
        check_val("mid_rst_err", cmd_err, 0);
        step();
        reset = 1'b0;
        step();
        check_val("rerel_ready", cmd_ready, 1);
        check_val("rerel_servo", servo, 0);
        idle_to_frame("after_reset_idle");
        measure_frame("G0", 50, 50, 50, 50, 50, 50, 0);
        measure_frame("G1", 50, 50, 50, 50, 50, 50, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
